umem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified memory between the instruction-cache fill path and the data-cache fill/writeback path. Accepts one request per side, grants exactly one, holds the memory strobes stable until the memory signals ready, then returns a one-cycle completion pulse to the owner. Sits between the cache controller and the unified memory; the controller issues requests instead of driving the memory directly.

---
 rtl/umem_arbiter.sv | 131 +++++++++++++
 tb/tb_umem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// umem_arbiter
//   Shares the single unified memory between the instruction-cache fill path
//   (I side, line reads only) and the data-cache fill/writeback path (D side,
//   line reads or writebacks). It grants one requester, latches that request,
//   and holds the memory strobes, address and write data steady until mem_rdy.
//   In that same cycle it raises a one-cycle done pulse to the owner.
//
//   Optional feature macro: ARB_RR_EN
//     defined   -> round-robin on simultaneous requests (last-grant register)
//     undefined -> fixed priority, D side wins ties
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req, i_addr         instruction line read request / line address
//   i_done                one-cycle pulse, instruction read complete
//   d_req, d_we, d_addr,  data request, 1 = writeback, line address,
//   d_wdata               writeback line
//   d_done                one-cycle pulse, data transaction complete
//   rd_data               memory read data (valid during a done pulse)
//   busy                  transaction in flight
//   mem_addr, mem_re,     unified memory address, read strobe,
//   mem_we, mem_wdata     write strobe, write data
//   mem_rd_data, mem_rdy  unified memory read data, completion
module umem_arbiter #(
    parameter int AW = 14,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          mem_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          re_reg;
    logic          we_reg;
    logic          grant_d;

`ifdef ARB_RR_EN
    // 1 when the most recent grant went to the D side; reset to I so the
    // first tie after reset goes to D.
    logic last_d_reg;

    assign grant_d = d_req && (!i_req || !last_d_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_reg <= 1'b0;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_d_reg <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    // Strobes are registered and only change on grant and on completion,
    // so the memory sees them constant for the whole busy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            re_reg    <= 1'b0;
            we_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_BUSY;
                        addr_reg  <= d_addr;
                        wdata_reg <= d_wdata;
                        re_reg    <= ~d_we;
                        we_reg    <= d_we;
                    end else if (i_req) begin
                        state    <= I_BUSY;
                        addr_reg <= i_addr;
                        re_reg   <= 1'b1;
                        we_reg   <= 1'b0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_rdy) begin
                        state  <= IDLE;
                        re_reg <= 1'b0;
                        we_reg <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    re_reg <= 1'b0;
                    we_reg <= 1'b0;
                end
            endcase
        end
    end

    // Done pulses follow mem_rdy in the same cycle; mem_rdy outside a busy
    // state never produces a pulse.
    assign i_done    = (state == I_BUSY) && mem_rdy;
    assign d_done    = (state == D_BUSY) && mem_rdy;
    assign busy      = (state != IDLE);
    assign rd_data   = mem_rd_data;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_re    = re_reg;
    assign mem_we    = we_reg;

endmodule

// File: tb/tb_umem_arbiter.sv
module tb_umem_arbiter;
    localparam int AW = 14;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_done;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rdy = 1'b0;

    int total = 0;
    int bad = 0;
    bit last_d = 1'b0;   // reference model: last grant went to D
    int txn_no = 0;

    umem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .rd_data(rd_data), .busy(busy),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Protocol rules checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_onehot", 64'(mem_re & mem_we), 64'd0);
            chk("done_onehot", 64'(i_done & d_done), 64'd0);
            chk("done_without_rdy", 64'((i_done | d_done) & ~mem_rdy), 64'd0);
        end
    end

    // Reference arbitration: single requester wins outright; on a tie the
    // D side wins (fixed) or the side not granted last wins (round-robin).
    function automatic bit pick(input bit ir, input bit dr);
        bit w;
        if (ir && dr) begin
`ifdef ARB_RR_EN
            w = !last_d;
`else
            w = 1'b1;
`endif
        end else begin
            w = dr;
        end
        last_d = w;
        return w;
    endfunction

    // One cycle: sample at the falling edge, return just after the next rising edge.
    task automatic sample(input string tag, input bit e_busy, input bit e_re, input bit e_we,
                          input logic [AW-1:0] e_addr, input bit chk_addr,
                          input logic [DW-1:0] e_wdata, input bit chk_wdata,
                          input bit e_idone, input bit e_ddone,
                          input logic [DW-1:0] e_rd, output bit got_d);
        @(negedge clk);
        chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
        chk({tag, ".mem_re"}, 64'(mem_re), 64'(e_re));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(e_we));
        chk({tag, ".i_done"}, 64'(i_done), 64'(e_idone));
        chk({tag, ".d_done"}, 64'(d_done), 64'(e_ddone));
        if (chk_addr) chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
        if (chk_wdata) chk({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        if (e_idone || e_ddone) chk({tag, ".rd_data"}, rd_data, e_rd);
        got_d = d_done;
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction from the IDLE cycle in which requests are
    // already presented. delay = busy cycles before mem_rdy.
    task automatic txn(input int delay, input logic [DW-1:0] rdv, input bit drop,
                       input bit scramble, output bit won_d);
        bit wd, ewe, g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        wd  = pick(i_req, d_req);
        ea  = wd ? d_addr : i_addr;
        ewe = wd ? d_we : 1'b0;
        ewd = d_wdata;
        mem_rdy = 1'($urandom_range(0, 1));   // ignored while idle
        mem_rd_data = {$urandom, $urandom};
        sample("idle", 0, 0, 0, '0, 0, '0, 0, 0, 0, '0, g);
        mem_rdy = 1'b0;
        for (int k = 0; k < delay; k++) begin
            if (scramble) begin
                i_addr  = AW'($urandom);
                d_addr  = AW'($urandom);
                d_wdata = {$urandom, $urandom};
                d_we    = 1'($urandom);
                i_req   = 1'($urandom);
                d_req   = 1'($urandom);
            end
            sample("wait", 1, !ewe, ewe, ea, 1, ewd, wd && ewe, 0, 0, '0, g);
        end
        mem_rdy = 1'b1;
        mem_rd_data = rdv;
        if (drop) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        sample("done", 1, !ewe, ewe, ea, 1, ewd, wd && ewe, !wd, wd, rdv, won_d);
        mem_rdy = 1'b0;
        txn_no++;
        $display("txn %0d winner=%s we=%0d addr=%h delay=%0d", txn_no, wd ? "D" : "I", ewe, ea, delay);
    endtask

    initial begin
        bit w;
        bit [2:0] seq;
        bit [2:0] exp_seq;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.mem_re", 64'(mem_re), 64'd0);
        chk("rst.mem_we", 64'(mem_we), 64'd0);
        chk("rst.mem_addr", 64'(mem_addr), 64'd0);
        chk("rst.mem_wdata", mem_wdata, 64'd0);
        chk("rst.i_done", 64'(i_done), 64'd0);
        chk("rst.d_done", 64'(d_done), 64'd0);
        rst_n = 1'b1;
        last_d = 1'b0;

        // Instruction read, mem_rdy in the third busy cycle
        i_req = 1'b1; i_addr = 14'h0010; d_req = 1'b0;
        txn(2, 64'h0004_0003_0002_0001, 1, 0, w);

        // mem_rdy held high, request held one cycle past done
        i_req = 1'b1; i_addr = 14'h0123;
        txn(0, {$urandom, $urandom}, 0, 0, w);
        txn(0, {$urandom, $urandom}, 1, 0, w);

        // Data writeback with requester inputs scrambled after grant
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h2A05; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        txn(3, {$urandom, $urandom}, 1, 1, w);
        i_req = 1'b0; d_req = 1'b0;

        // Reset in the middle of a writeback
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h1111; d_wdata = 64'h0123_4567_89AB_CDEF;
        w = pick(i_req, d_req);
        sample("pre_rst_idle", 0, 0, 0, '0, 0, '0, 0, 0, 0, '0, w);
        sample("pre_rst_busy", 1, 0, 1, 14'h1111, 1, 64'h0123_4567_89AB_CDEF, 1, 0, 0, '0, w);
        mem_rdy = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.mem_we", 64'(mem_we), 64'd0);
        chk("midrst.mem_re", 64'(mem_re), 64'd0);
        chk("midrst.d_done", 64'(d_done), 64'd0);
        d_req = 1'b0; mem_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_d = 1'b0;
        i_req = 1'b1; i_addr = 14'h0777;
        txn(1, {$urandom, $urandom}, 1, 0, w);

        // Both sides requesting through three transactions
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 14'h0042; d_addr = 14'h3003;
        seq = '0;
        txn(1, {$urandom, $urandom}, 0, 0, w); seq = {seq[1:0], w};
        txn(1, {$urandom, $urandom}, 0, 0, w); seq = {seq[1:0], w};
        txn(1, {$urandom, $urandom}, 1, 0, w); seq = {seq[1:0], w};
`ifdef ARB_RR_EN
        exp_seq = 3'b101;
`else
        exp_seq = 3'b111;
`endif
        chk("tie_grant_sequence", 64'(seq), 64'(exp_seq));

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            i_addr  = AW'($urandom);
            d_addr  = AW'($urandom);
            d_wdata = {$urandom, $urandom};
            d_we    = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin i_req = 1'b1; d_req = 1'b0; end
                1: begin i_req = 1'b0; d_req = 1'b1; end
                default: begin i_req = 1'b1; d_req = 1'b1; end
            endcase
            txn(int'($urandom_range(0, 8)), {$urandom, $urandom}, 1, 1, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
